// File: rtl/bcd_serial_adder.sv
// Three-digit BCD adder that sums one decimal digit per clock (ones, tens, hundreds)
// with a rippling decimal carry, flagging operands that contain non-BCD digits.
module bcd_serial_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] x_ones,
  input  logic [3:0] x_tens,
  input  logic [3:0] x_huns,
  input  logic [3:0] y_ones,
  input  logic [3:0] y_tens,
  input  logic [3:0] y_huns,
  output logic [3:0] out_ones,
  output logic [3:0] out_tens,
  output logic [3:0] out_huns,
  output logic       carry,
  output logic       invalid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ONES, TENS, HUNS} state_t;

  state_t     state, state_next;
  logic [3:0] xo_q, xt_q, xh_q, yo_q, yt_q, yh_q;
  logic [3:0] wo_q, wt_q;
  logic       c_q, invalid_pending;
  logic [3:0] x_d, y_d, digit;
  logic [4:0] s;
  logic       c_next;
  logic       latch_invalid;

  assign latch_invalid = (x_ones > 4'd9) | (x_tens > 4'd9) | (x_huns > 4'd9) |
                         (y_ones > 4'd9) | (y_tens > 4'd9) | (y_huns > 4'd9);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ONES;
      ONES:    state_next = TENS;
      TENS:    state_next = HUNS;
      HUNS:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One shared digit adder; the state picks which operand digit pair it sees.
  always_comb begin
    x_d    = '0;
    y_d    = '0;
    digit  = '0;
    c_next = 1'b0;
    case (state)
      ONES:    begin x_d = xo_q; y_d = yo_q; end
      TENS:    begin x_d = xt_q; y_d = yt_q; end
      HUNS:    begin x_d = xh_q; y_d = yh_q; end
      default: ;
    endcase
    s = {1'b0, x_d} + {1'b0, y_d} + {4'b0000, c_q};
    if (s > 5'd9) begin
      digit  = 4'(s - 5'd10);
      c_next = 1'b1;
    end else begin
      digit  = s[3:0];
      c_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xo_q <= '0; xt_q <= '0; xh_q <= '0;
      yo_q <= '0; yt_q <= '0; yh_q <= '0;
      wo_q <= '0; wt_q <= '0;
      c_q <= 1'b0;
      invalid_pending <= 1'b0;
      out_ones <= '0; out_tens <= '0; out_huns <= '0;
      carry <= 1'b0;
      invalid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          xo_q <= x_ones; xt_q <= x_tens; xh_q <= x_huns;
          yo_q <= y_ones; yt_q <= y_tens; yh_q <= y_huns;
          c_q <= 1'b0;
          invalid_pending <= latch_invalid;
        end
        ONES: begin wo_q <= digit; c_q <= c_next; end
        TENS: begin wt_q <= digit; c_q <= c_next; end
        HUNS: begin
          // Results only become visible here, so partial sums are never exposed.
          c_q <= c_next;
          invalid <= invalid_pending;
          done <= 1'b1;
          if (invalid_pending) begin
            out_ones <= '0; out_tens <= '0; out_huns <= '0;
            carry <= 1'b0;
          end else begin
            out_ones <= wo_q; out_tens <= wt_q; out_huns <= digit;
            carry <= c_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
